dispatch_buffer: RTL and testbench
==================================

# dispatch_buffer

Producer side of the issue-queue write interface: buffers renamed instruction entries from the rename stage and drives `do_write`/`write_data` into the issue queue under its `full` back-pressure. Also issues the destination busy-bit clear (`do_clear_2BB`/`clear_index_2BB`) in the same cycle each entry is written, so the busy bits and the queue contents stay consistent. Flushes on `mispredict` or `flush_fCOM`, and holds on `FREEZE`.

## Interface
- `DEPTH`, 4, buffer entries; power of two, ≥2
- `ENTRY_W`, 192, issue-queue entry width
- `PHY_W`, 6, physical register index width
- `CLK`  in  1  clock; all state on rising edge
- `RESET`  in  1  asynchronous, active-high reset
- `FREEZE`  in  1  pipeline hold
- `mispredict`  in  1  branch mispredict flush
- `flush_fCOM`  in  1  commit-stage flush
- `in_valid`  in  1  rename stage presents an entry
- `in_data`  in  ENTRY_W  renamed entry
- `in_ready`  out  1  entry accepted when `in_valid && in_ready`
- `iq_full`  in  1  issue queue `full`
- `do_write`  out  1  write strobe to issue queue
- `write_data`  out  ENTRY_W  entry to issue queue; bit 191 forced to 1
- `do_clear_2BB`  out  1  clear busy bit of destination
- `clear_index_2BB`  out  PHY_W  destination physical register (`write_data[179:174]`)
- `count`  out  clog2(DEPTH)+1  occupancy
- `empty`  out  1  `count == 0`

## Operation
- Circular FIFO with head and tail pointers of clog2(DEPTH) bits, wrapping modulo DEPTH. `count` is a separate register.
- Flush: `flush = mispredict || flush_fCOM`.
- `in_ready = (count < DEPTH) && !FREEZE && !flush`. It never depends on `iq_full`, so there is no combinational path from the issue queue to rename.
- Pop condition: `do_write = !empty && !iq_full && !FREEZE && !flush`.
- `write_data` is the head entry with bit 191 set to 1. It is 0 whenever `do_write` is 0.
- Busy-bit clear:
  - `do_clear_2BB = do_write && head[140]`
  - `clear_index_2BB = head[179:174]`, or 0 when `do_clear_2BB` is 0
- Push and pop in the same cycle: `count` is unchanged and both pointers advance. This is legal at `count == DEPTH` only if `in_ready` was already 1, which it is not, so no push occurs when full.
- Flush has priority over everything else. On the next edge, pointers and `count` go to 0, and no push or pop occurs in the flush cycle.
- `FREEZE` (with no flush): all state holds, `do_write = 0`, `in_ready = 0`.
- Reset values:
  - `count`, pointers = 0
  - `do_write`, `do_clear_2BB`, `write_data`, `clear_index_2BB` = 0
  - `empty` = 1
  - `in_ready` = 1 once `RESET` deasserts, with `FREEZE` and flush low
- Reset asserted mid-operation discards all entries immediately (asynchronous).

## Timing
- Base latency: an entry accepted at edge N is at the head and drives `do_write` during cycle N+1, provided `iq_full` is low.
- Throughput is 1 entry/cycle sustained when `iq_full` is low.
- While `iq_full` is high, the head is held stable. `do_write` stays low; there is no retry semantics.
- `count`/`empty` update on the edge following the push or pop.

## Configuration
- `DISPATCH_BYPASS_EN` defined:
  - Condition: `empty && in_valid && in_ready && !iq_full`.
  - Under that condition `in_data` passes through combinationally: `do_write = 1`, `write_data = {1'b1, in_data[190:0]}`, and the busy-bit clear is taken from `in_data`.
  - Nothing is stored; latency is 0 cycles.
- `DISPATCH_BYPASS_EN` undefined: every entry goes through storage, with a minimum latency of 1 cycle.

## Structure
- Package `dispatch_pkg`:
  - `ENTRY_W`
  - field constants `IQ_VALID_BIT=191`, `IQ_DEST_HI=179`, `IQ_DEST_LO=174`, `IQ_SRC0_HI=166`, `IQ_SRC0_LO=161`, `IQ_SRC1_HI=173`, `IQ_SRC1_LO=168`, `IQ_WB_BIT=140`
  - helper function that extracts the destination field
- Sub-module `dispatch_fifo_mem`: DEPTH×ENTRY_W register array with one write port and one asynchronous read port. Pointer, count and handshake logic stay in `dispatch_buffer`.

## Test plan
- Reset, then push entries A (bit140=1, dest=12) and B (bit140=0, dest=5) on consecutive cycles with `iq_full` low → `do_write` is high for 2 cycles. `clear_index_2BB`=12 with `do_clear_2BB`=1, then `do_clear_2BB`=0. `write_data[191]`=1 in both cycles.
- Hold `iq_full`=1 and push 4 entries → `count`=4, `in_ready`=0, `do_write`=0. Drop `iq_full` → the 4 entries drain in order, one per cycle, and `empty`=1 after the fourth.
- With `count`=2, assert `mispredict` for one cycle while `in_valid`=1 → no push or pop that cycle. Next cycle `count`=0, `do_write`=0, `in_ready`=1.
- With `count`=3, assert `FREEZE` for 3 cycles → `count`, head entry and pointers unchanged; `do_write`=0 and `in_ready`=0 throughout.
- Push and pop simultaneously for 10 cycles at `count`=2 → `count` stays 2, pointers wrap, and output order matches input order.
- With `DISPATCH_BYPASS_EN`: empty buffer, `in_valid`=1, dest=33, bit140=1 → same-cycle `do_write`=1, `clear_index_2BB`=33, and `count` stays 0.

Source files
------------

// File: rtl/dispatch_pkg.sv
// Issue-queue entry layout shared by the dispatch buffer and its storage.
package dispatch_pkg;

  localparam int ENTRY_W      = 192;
  localparam int IQ_VALID_BIT = 191;
  localparam int IQ_DEST_HI   = 179;
  localparam int IQ_DEST_LO   = 174;
  localparam int IQ_SRC0_HI   = 166;
  localparam int IQ_SRC0_LO   = 161;
  localparam int IQ_SRC1_HI   = 173;
  localparam int IQ_SRC1_LO   = 168;
  localparam int IQ_WB_BIT    = 140;

  function automatic logic [IQ_DEST_HI-IQ_DEST_LO:0] dest_of(
    input logic [ENTRY_W-1:0] e
  );
    return e[IQ_DEST_HI:IQ_DEST_LO];
  endfunction

endpackage

// File: rtl/dispatch_fifo_mem.sv
// Entry storage for the dispatch buffer: one write port, one async read port.
module dispatch_fifo_mem #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 192,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               CLK,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dispatch_buffer.sv
// Rename -> issue-queue dispatch FIFO with same-cycle busy-bit clear.
// DISPATCH_BYPASS_EN: pass entries straight through when empty.
module dispatch_buffer #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 192,
  parameter int PHY_W   = 6
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       FREEZE,
  input  logic                       mispredict,
  input  logic                       flush_fCOM,
  input  logic                       in_valid,
  input  logic [ENTRY_W-1:0]         in_data,
  output logic                       in_ready,
  input  logic                       iq_full,
  output logic                       do_write,
  output logic [ENTRY_W-1:0]         write_data,
  output logic                       do_clear_2BB,
  output logic [PHY_W-1:0]           clear_index_2BB,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  import dispatch_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]      head_q;
  logic [PW-1:0]      tail_q;
  logic [CW-1:0]      count_q;
  logic [ENTRY_W-1:0] head_data;
  logic [ENTRY_W-1:0] src;
  logic               flush;
  logic               push;
  logic               pop;
  logic               byp;

  dispatch_fifo_mem #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_mem (
    .CLK   (CLK),
    .we    (push),
    .waddr (tail_q),
    .wdata (in_data),
    .raddr (head_q),
    .rdata (head_data)
  );

  assign flush    = mispredict || flush_fCOM;
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign in_ready = (count_q < CW'(DEPTH)) && !FREEZE && !flush;

`ifdef DISPATCH_BYPASS_EN
  assign byp = empty && in_valid && in_ready && !iq_full;
`else
  assign byp = 1'b0;
`endif

  assign pop  = !empty && !iq_full && !FREEZE && !flush;
  assign push = in_valid && in_ready && !byp;
  assign src  = byp ? in_data : head_data;

  always_comb begin
    write_data      = '0;
    do_write        = pop || byp;
    do_clear_2BB    = 1'b0;
    clear_index_2BB = '0;
    if (do_write) begin
      write_data               = src;
      write_data[IQ_VALID_BIT] = 1'b1;
      do_clear_2BB             = src[IQ_WB_BIT];
    end
    if (do_clear_2BB)
      clear_index_2BB = PHY_W'(dest_of(src));
  end

  // Flush wins over push/pop; FREEZE already masks both.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      if (push && !pop)
        count_q <= count_q + 1'b1;
      else if (pop && !push)
        count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_dispatch_buffer.sv
// Directed vector bench for dispatch_buffer.
module tb_dispatch_buffer;

  localparam int EW = 192;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          FREEZE = 1'b0;
  logic          mispredict = 1'b0;
  logic          flush_fCOM = 1'b0;
  logic          in_valid = 1'b0;
  logic [EW-1:0] in_data = '0;
  logic          in_ready;
  logic          iq_full = 1'b0;
  logic          do_write;
  logic [EW-1:0] write_data;
  logic          do_clear_2BB;
  logic [5:0]    clear_index_2BB;
  logic [2:0]    count;
  logic          empty;

  int n_vec = 0;
  int n_err = 0;

  dispatch_buffer dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .FREEZE          (FREEZE),
    .mispredict      (mispredict),
    .flush_fCOM      (flush_fCOM),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .iq_full         (iq_full),
    .do_write        (do_write),
    .write_data      (write_data),
    .do_clear_2BB    (do_clear_2BB),
    .clear_index_2BB (clear_index_2BB),
    .count           (count),
    .empty           (empty)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       v;
    logic [7:0] tag;
    logic       full, frz, mis, fc;
    logic       dw;
    logic [7:0] wtag;
    logic [2:0] cnt;
    logic       rdy, emp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [5:0] dest_f(input logic [7:0] t);
    case (t)
      8'd1:    return 6'd12;
      8'd2:    return 6'd5;
      8'd40:   return 6'd33;
      default: return t[5:0] ^ 6'h15;
    endcase
  endfunction

  function automatic logic wb_f(input logic [7:0] t);
    case (t)
      8'd1:    return 1'b1;
      8'd2:    return 1'b0;
      8'd40:   return 1'b1;
      default: return t[0];
    endcase
  endfunction

  function automatic logic [EW-1:0] ent(input logic [7:0] t);
    logic [EW-1:0] d;
    d          = '0;
    d[7:0]     = t;
    d[190:183] = ~t;
    d[179:174] = dest_f(t);
    d[140]     = wb_f(t);
    return d;
  endfunction

  function automatic vec_t mk(
    input logic v, input logic [7:0] tag,
    input logic full, input logic frz, input logic mis, input logic fc,
    input logic dw, input logic [7:0] wtag, input logic [2:0] cnt,
    input logic rdy, input logic emp
  );
    vec_t r;
    r.v = v; r.tag = tag; r.full = full; r.frz = frz;
    r.mis = mis; r.fc = fc; r.dw = dw; r.wtag = wtag;
    r.cnt = cnt; r.rdy = rdy; r.emp = emp;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [EW-1:0] act,
                     input logic [EW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t x, input int idx);
    logic [EW-1:0] ew;
    logic          eclr;
    @(negedge CLK);
    in_valid   = x.v;
    in_data    = x.v ? ent(x.tag) : '0;
    iq_full    = x.full;
    FREEZE     = x.frz;
    mispredict = x.mis;
    flush_fCOM = x.fc;
    #1;
    ew = '0;
    if (x.dw) begin
      ew      = ent(x.wtag);
      ew[191] = 1'b1;
    end
    eclr = x.dw && wb_f(x.wtag);
    chk($sformatf("v%0d do_write", idx), EW'(do_write), EW'(x.dw));
    chk($sformatf("v%0d write_data", idx), write_data, ew);
    chk($sformatf("v%0d do_clear", idx), EW'(do_clear_2BB), EW'(eclr));
    chk($sformatf("v%0d clear_idx", idx), EW'(clear_index_2BB),
        EW'(eclr ? dest_f(x.wtag) : 6'd0));
    chk($sformatf("v%0d count", idx), EW'(count), EW'(x.cnt));
    chk($sformatf("v%0d in_ready", idx), EW'(in_ready), EW'(x.rdy));
    chk($sformatf("v%0d empty", idx), EW'(empty), EW'(x.emp));
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst count", EW'(count), '0);
    chk("rst empty", EW'(empty), EW'(1'b1));
    chk("rst do_write", EW'(do_write), '0);
    chk("rst write_data", write_data, '0);
    chk("rst do_clear", EW'(do_clear_2BB), '0);
    RESET = 1'b0;

`ifndef DISPATCH_BYPASS_EN
    // basic two-entry dispatch
    tbl.push_back(mk(0, 0, 0,0,0,0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 0,0,0,0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 2, 0,0,0,0, 1, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0,0,0,0, 1, 2, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0, 0, 0, 1, 1));
    // fill under back-pressure, then drain
    tbl.push_back(mk(1, 3, 1,0,0,0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 4, 1,0,0,0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 5, 1,0,0,0, 0, 0, 2, 1, 0));
    tbl.push_back(mk(1, 6, 1,0,0,0, 0, 0, 3, 1, 0));
    tbl.push_back(mk(1, 7, 1,0,0,0, 0, 0, 4, 0, 0));
    tbl.push_back(mk(0, 0, 0,0,0,0, 1, 3, 4, 0, 0));
    tbl.push_back(mk(0, 0, 0,0,0,0, 1, 4, 3, 1, 0));
    tbl.push_back(mk(0, 0, 0,0,0,0, 1, 5, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0,0,0,0, 1, 6, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0, 0, 0, 1, 1));
    // mispredict at count 2
    tbl.push_back(mk(1, 8, 1,0,0,0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 9, 1,0,0,0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1,10, 0,0,1,0, 0, 0, 2, 0, 0));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0, 0, 0, 1, 1));
    // freeze at count 3
    tbl.push_back(mk(1,11, 1,0,0,0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1,12, 1,0,0,0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1,13, 1,0,0,0, 0, 0, 2, 1, 0));
    tbl.push_back(mk(1,14, 0,1,0,0, 0, 0, 3, 0, 0));
    tbl.push_back(mk(1,14, 0,1,0,0, 0, 0, 3, 0, 0));
    tbl.push_back(mk(1,14, 0,1,0,0, 0, 0, 3, 0, 0));
    tbl.push_back(mk(0, 0, 0,0,0,0, 1,11, 3, 1, 0));
    tbl.push_back(mk(0, 0, 0,0,0,0, 1,12, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0,0,0,0, 1,13, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0, 0, 0, 1, 1));
    // commit flush
    tbl.push_back(mk(1,15, 1,0,0,0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1,16, 1,0,0,1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0, 0, 0, 1, 1));
    // steady push+pop at count 2, pointers wrap
    tbl.push_back(mk(1,20, 1,0,0,0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1,21, 1,0,0,0, 0, 0, 1, 1, 0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(1, 8'(22+i), 0,0,0,0, 1, 8'(20+i), 2, 1, 0));
    tbl.push_back(mk(0, 0, 0,0,0,0, 1,30, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0,0,0,0, 1,31, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0,0,0,0, 0, 0, 0, 1, 1));
`endif
    // setup for asynchronous reset mid-operation
    tbl.push_back(mk(1,50, 1,0,0,0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1,51, 1,0,0,0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1,0,0,0, 0, 0, 2, 1, 0));

    foreach (tbl[i]) apply(tbl[i], i);

    @(negedge CLK);
    iq_full = 1'b0;
    #2 RESET = 1'b1;
    #1;
    chk("async rst count", EW'(count), '0);
    chk("async rst empty", EW'(empty), EW'(1'b1));
    chk("async rst do_write", EW'(do_write), '0);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("post rst do_write", EW'(do_write), '0);
    chk("post rst in_ready", EW'(in_ready), EW'(1'b1));

`ifdef DISPATCH_BYPASS_EN
    apply(mk(1,40, 0,0,0,0, 1,40, 0, 1, 1), 900);
    chk("byp clear_idx", EW'(clear_index_2BB), EW'(6'd33));
    apply(mk(0, 0, 0,0,0,0, 0, 0, 0, 1, 1), 901);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
